// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressed data memory behind a simple req/ready/ack handshake.
//   Each accepted access completes with a one-cycle ack exactly LAT cycles
//   after the accepting edge. Out-of-range accesses, and misaligned ones when
//   ALIGN=1, complete with err=1, rdata=0 and leave memory untouched.
//
// Parameters
//   DATA_W      access width in bits (multiple of 8, >= 8)
//   ADDR_W      byte-address width
//   DEPTH_BYTES number of byte locations (1 .. 2^ADDR_W)
//   LAT         acceptance-to-ack latency in cycles (1 .. 8)
//   ALIGN       0 = misaligned accesses permitted, 1 = misaligned is an error
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   req    access request, accepted when ready=1
//   we     1 = write, 0 = read
//   addr   lowest byte address of the access
//   wdata  write data, little-endian
//   be     write byte enables, bit i selects wdata byte i
//   ready  request can be accepted this cycle (IDLE only)
//   ack    one-cycle completion pulse
//   rdata  read result, valid with ack, 0 otherwise
//   err    access rejected, valid with ack, 0 otherwise
module data_memory_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 512,
    parameter int LAT         = 1,
    parameter int ALIGN       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int unsigned NB       = DATA_W / 8;
    localparam int          IDX_W    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [ADDR_W:0]   SPAN_L   = (ADDR_W+1)'(NB - 1);
    localparam logic [ADDR_W-1:0] NB_A     = ADDR_W'(NB);
    localparam logic [2:0]        CNT_LOAD = (LAT > 1) ? 3'(LAT - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [NB-1:0]       cap_be;

    logic [7:0]          mem [DEPTH_BYTES];

    // Operation completing on this edge. With LAT=1 the access completes on
    // its accepting edge, so the live inputs are used instead of the capture.
    logic                commit;
    logic                op_we;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;
    logic [NB-1:0]       op_be;
    logic [ADDR_W:0]     op_last;
    logic                op_legal;
    logic [DATA_W-1:0]   rd_word;

    always_comb begin
        op_we    = cap_we;
        op_addr  = cap_addr;
        op_wdata = cap_wdata;
        op_be    = cap_be;
        commit   = 1'b0;
        if (state == IDLE) begin
            op_we    = we;
            op_addr  = addr;
            op_wdata = wdata;
            op_be    = be;
            commit   = req && (LAT == 1) && rst_n;
        end else if (state == WAIT) begin
            commit   = (cnt == '0) && rst_n;
        end

        // One extra bit so the last byte address cannot wrap past zero.
        op_last  = {1'b0, op_addr} + SPAN_L;
        op_legal = (op_last < DEPTH_L) &&
                   !((ALIGN == 1) && ((op_addr % NB_A) != '0));

        rd_word = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            rd_word[8*i +: 8] = mem[IDX_W'(op_addr) + IDX_W'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        cap_be    <= be;
                        ready     <= 1'b0;
                        state     <= WAIT;
                        cnt       <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    rdata <= '0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase

            // Completion overrides the WAIT entry above when LAT=1.
            if (commit) begin
                state <= RESP;
                cnt   <= '0;
                ack   <= 1'b1;
                err   <= !op_legal;
                rdata <= (op_legal && !op_we) ? rd_word : '0;
            end
        end
    end

    // Storage is not reset; commit is already gated by rst_n.
    always_ff @(posedge clk) begin
        if (commit && op_legal && op_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (op_be[i]) begin
                    mem[IDX_W'(op_addr) + IDX_W'(i)] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance 0: defaults (16-bit, LAT=1, ALIGN=0, 512 bytes)
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0;
    logic [1:0]  be0 = '0;
    logic        ready0, ack0, err0;
    logic [15:0] rdata0;

    // Instance 1: 32-bit, LAT=3, ALIGN=1, 256 bytes
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic [3:0]  be1 = '0;
    logic        ready1, ack1, err1;
    logic [31:0] rdata1;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] m0 [512];
    logic [7:0] m1 [256];

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(512), .LAT(1), .ALIGN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0));

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH_BYTES(256), .LAT(3), .ALIGN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .be(be1), .ready(ready1), .ack(ack1), .rdata(rdata1), .err(err1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_rdy(int s);
        return (s != 0) ? {31'd0, ready1} : {31'd0, ready0};
    endfunction
    function automatic logic [31:0] obs_ack(int s);
        return (s != 0) ? {31'd0, ack1} : {31'd0, ack0};
    endfunction
    function automatic logic [31:0] obs_err(int s);
        return (s != 0) ? {31'd0, err1} : {31'd0, err0};
    endfunction
    function automatic logic [31:0] obs_rd(int s);
        return (s != 0) ? rdata1 : {16'd0, rdata0};
    endfunction

    // One complete access; req is held high through the busy cycles to show
    // it is not accepted a second time.
    task automatic do_access(input int sel, input logic w, input int unsigned a,
                             input logic [31:0] wd, input logic [3:0] bem,
                             output logic [31:0] got);
        int unsigned nb, dep, lat, guard;
        bit          bad;
        logic [31:0] exp_rd;
        nb  = (sel != 0) ? 4 : 2;
        dep = (sel != 0) ? 256 : 512;
        lat = (sel != 0) ? 3 : 1;
        bad = (a + nb - 1 >= dep) || ((sel != 0) && (a % nb != 0));

        exp_rd = '0;
        if (!bad) begin
            for (int unsigned i = 0; i < nb; i++)
                exp_rd[8*i +: 8] = (sel != 0) ? m1[a+i] : m0[a+i];
            if (w) begin
                for (int unsigned i = 0; i < nb; i++) begin
                    if (bem[i]) begin
                        if (sel != 0) m1[a+i] = wd[8*i +: 8];
                        else          m0[a+i] = wd[8*i +: 8];
                    end
                end
            end
        end
        if (bad) exp_rd = '0;

        @(negedge clk);
        guard = 0;
        while (obs_rdy(sel) !== 32'd1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_idle", obs_rdy(sel), 32'd1);

        if (sel != 0) begin
            req1 = 1'b1; we1 = w; addr1 = a[15:0]; wdata1 = wd; be1 = bem;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a[15:0]; wdata0 = wd[15:0]; be0 = bem[1:0];
        end
        @(posedge clk);

        got = '0;
        for (int unsigned k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("ready_busy", obs_rdy(sel), 32'd0);
            chk("ack_timing", obs_ack(sel), (k == lat) ? 32'd1 : 32'd0);
            if (k == lat) begin
                got = obs_rd(sel);
                chk("err", obs_err(sel), bad ? 32'd1 : 32'd0);
                if (!w || bad) chk("rdata", got, exp_rd);
                if (sel != 0) req1 = 1'b0; else req0 = 1'b0;
            end else begin
                chk("rdata_idle_busy", obs_rd(sel), 32'd0);
            end
        end
        @(negedge clk);
        chk("ready_after", obs_rdy(sel), 32'd1);
        chk("ack_after", obs_ack(sel), 32'd0);
        chk("err_after", obs_err(sel), 32'd0);
        chk("rdata_after", obs_rd(sel), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          sel;
        int unsigned a, dep, pick;

        for (int i = 0; i < 512; i++) m0[i] = 8'h00;
        for (int i = 0; i < 256; i++) m1[i] = 8'h00;

        // Reset holds outputs regardless of the running clock
        #23;
        chk("rst_ready0", {31'd0, ready0}, 32'd1);
        chk("rst_ack0",   {31'd0, ack0},   32'd0);
        chk("rst_err0",   {31'd0, err0},   32'd0);
        chk("rst_rdata0", {16'd0, rdata0}, 32'd0);
        chk("rst_ready1", {31'd0, ready1}, 32'd1);
        chk("rst_rdata1", rdata1,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bring storage to a known state
        for (int unsigned i = 0; i < 512; i += 2) do_access(0, 1'b1, i, 32'd0, 4'h3, rd);
        for (int unsigned i = 0; i < 256; i += 4) do_access(1, 1'b1, i, 32'd0, 4'hF, rd);

        // Full write then read
        do_access(0, 1'b1, 16'h0010, 32'h0000BEEF, 4'h3, rd);
        do_access(0, 1'b0, 16'h0010, 32'd0, 4'h0, rd);
        chk("beef_read", rd, 32'h0000BEEF);
        do_access(0, 1'b0, 16'h0011, 32'd0, 4'h0, rd);
        chk("odd_read_be_byte", rd, 32'h000000BE);

        // Partial byte enable
        do_access(0, 1'b1, 16'h0010, 32'h00001234, 4'h1, rd);
        do_access(0, 1'b0, 16'h0010, 32'd0, 4'h3, rd);
        chk("be_partial", rd, 32'h0000BE34);

        // be=0 write changes nothing
        do_access(0, 1'b1, 16'h0030, 32'h0000FFFF, 4'h0, rd);
        do_access(0, 1'b0, 16'h0030, 32'd0, 4'h0, rd);
        chk("be_zero", rd, 32'h00000000);

        // Bounds, no wrap
        do_access(0, 1'b0, 16'h01FF, 32'd0, 4'h0, rd);
        do_access(0, 1'b1, 16'hFFFF, 32'h0000DEAD, 4'h3, rd);
        do_access(0, 1'b0, 16'h0000, 32'd0, 4'h0, rd);
        chk("no_wrap_mem0", rd, 32'h00000000);
        do_access(0, 1'b1, 16'h01FE, 32'h0000A1B2, 4'h3, rd);
        do_access(0, 1'b0, 16'h01FE, 32'd0, 4'h0, rd);
        chk("last_word", rd, 32'h0000A1B2);

        // Misaligned permitted when ALIGN=0
        do_access(0, 1'b1, 16'h0003, 32'h00005566, 4'h3, rd);
        do_access(0, 1'b0, 16'h0003, 32'd0, 4'h0, rd);
        chk("misaligned_ok", rd, 32'h00005566);

        // 32-bit, LAT=3 instance: latency and alignment errors
        do_access(1, 1'b1, 16'h0040, 32'h89ABCDEF, 4'hF, rd);
        do_access(1, 1'b0, 16'h0040, 32'd0, 4'h0, rd);
        chk("lat3_read", rd, 32'h89ABCDEF);
        do_access(1, 1'b1, 16'h0002, 32'hCAFEF00D, 4'hF, rd);
        do_access(1, 1'b0, 16'h0000, 32'd0, 4'h0, rd);
        chk("misaligned_nowrite_lo", rd, 32'h00000000);
        do_access(1, 1'b0, 16'h0004, 32'd0, 4'h0, rd);
        chk("misaligned_nowrite_hi", rd, 32'h00000000);
        do_access(1, 1'b0, 16'h00FC, 32'd0, 4'h0, rd);
        do_access(1, 1'b0, 16'h00FD, 32'd0, 4'h0, rd);
        do_access(1, 1'b1, 16'h0100, 32'h11111111, 4'hF, rd);

        // Reset in the middle of a write aborts it
        do_access(1, 1'b1, 16'h0020, 32'hA5A55A5A, 4'hF, rd);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 32'h11223344; be1 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready1}, 32'd1);
        chk("abort_ack",   {31'd0, ack1},   32'd0);
        chk("abort_err",   {31'd0, err1},   32'd0);
        chk("abort_rdata", rdata1,          32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1, 1'b0, 16'h0020, 32'd0, 4'h0, rd);
        chk("abort_prior", rd, 32'hA5A55A5A);

        // Randomized traffic against the byte-array model
        for (int n = 0; n < 160; n++) begin
            sel  = int'($urandom_range(0, 1));
            dep  = (sel != 0) ? 256 : 512;
            pick = $urandom_range(0, 9);
            if (pick < 7)       a = $urandom_range(0, dep - 1);
            else if (pick < 9)  a = $urandom_range(dep - 6, dep + 2);
            else                a = $urandom_range(0, 16'hFFFF);
            if (sel != 0 && $urandom_range(0, 1) == 1) a = a & ~32'd3;
            do_access(sel, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
